// File: rtl/noc_pkg.sv
// Shared NoC switch definitions: arbiter state encoding and default geometry.
package noc_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_e;

   localparam int NOC_NREQ = 4;
   localparam int NOC_WID  = 32;

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational round-robin picker: returns the first set request after
// last_gnt_i, wrapping modulo N.
module noc_rr_pick
   import noc_pkg::*;
#(
   parameter int N  = NOC_NREQ,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_gnt_i,
   output logic          valid_o,
   output logic [IW-1:0] idx_o
);

   int unsigned   j;
   logic [IW-1:0] jj;

   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      j       = 0;
      jj      = '0;
      // Visit last_gnt+1 first so the previous winner is checked last.
      for (int k = 1; k <= N; k++) begin
         j  = (int'(last_gnt_i) + k) % N;
         jj = IW'(j);
         if (!valid_o && req_i[jj]) begin
            valid_o = 1'b1;
            idx_o   = jj;
         end
      end
   end

endmodule

// File: rtl/noc_fifo_rr_arb.sv
// Packet-locked round-robin merge of NREQ upstream FIFOs into one downstream FIFO.
// Define ARB_TIMEOUT_EN to force-release a lock stalled for TIMEOUT cycles.
module noc_fifo_rr_arb
   import noc_pkg::*;
#(
   parameter int WID     = NOC_WID,
   parameter int NREQ    = NOC_NREQ,
   parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                softreset,
   input  logic [NREQ-1:0]     in_empty,
   input  logic [NREQ*WID-1:0] in_data,
   input  logic [NREQ-1:0]     in_last,
   output logic [NREQ-1:0]     in_readout,
   input  logic                out_full,
   output logic                out_vld,
   output logic [WID-1:0]      out_data,
   output logic                out_last,
   output logic [IDW-1:0]      out_id,
   output logic                busy,
   output logic                timeout_err
);

   arb_state_e     state_q, state_d;
   logic [IDW-1:0] lock_id_q, lock_id_d;
   logic [IDW-1:0] last_gnt_q, last_gnt_d;

   logic           pick_vld;
   logic [IDW-1:0] pick_idx;
   logic [IDW-1:0] sel;
   logic           src_ok;
   logic           xfer;
   logic           force_rel;
   logic [WID-1:0] data_arr [NREQ];

   noc_rr_pick #(
      .N  (NREQ),
      .IW (IDW)
   ) u_pick (
      .req_i      (~in_empty),
      .last_gnt_i (last_gnt_q),
      .valid_o    (pick_vld),
      .idx_o      (pick_idx)
   );

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         data_arr[i] = in_data[i*WID +: WID];
      end
   end

   // While locked only the owner is eligible; reset and softreset block any pop.
   always_comb begin
      state_d    = state_q;
      lock_id_d  = lock_id_q;
      last_gnt_d = last_gnt_q;
      sel        = (state_q == ARB_LOCK) ? lock_id_q : pick_idx;
      src_ok     = (state_q == ARB_LOCK) ? !in_empty[sel] : pick_vld;
      xfer       = src_ok && !out_full && !softreset && !rst && !force_rel;

      if (xfer) begin
         last_gnt_d = sel;
         if (state_q == ARB_IDLE && !in_last[sel]) begin
            state_d   = ARB_LOCK;
            lock_id_d = sel;
         end else if (state_q == ARB_LOCK && in_last[sel]) begin
            state_d = ARB_IDLE;
         end
      end
      if (force_rel) begin
         state_d = ARB_IDLE;
      end
   end

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         in_readout[i] = xfer && (sel == IDW'(i));
      end
   end

   assign out_vld  = xfer;
   assign out_data = data_arr[sel];
   assign out_last = in_last[sel];
   assign out_id   = sel;
   assign busy     = (state_q == ARB_LOCK);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ARB_IDLE;
         lock_id_q  <= '0;
         last_gnt_q <= IDW'(NREQ - 1);
      end else if (softreset) begin
         state_q    <= ARB_IDLE;
         lock_id_q  <= '0;
         last_gnt_q <= IDW'(NREQ - 1);
      end else begin
         state_q    <= state_d;
         lock_id_q  <= lock_id_d;
         last_gnt_q <= last_gnt_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int SCW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
   logic           timeout_err_q;

   assign force_rel = (state_q == ARB_LOCK) && (stall_cnt_q == SCW'(TIMEOUT));

   // Only an empty owner counts as a stall; downstream back-pressure does not.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (state_q != ARB_LOCK || force_rel || xfer) begin
         stall_cnt_d = '0;
      end else if (in_empty[lock_id_q]) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q   <= '0;
         timeout_err_q <= 1'b0;
      end else if (softreset) begin
         stall_cnt_q   <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         stall_cnt_q   <= stall_cnt_d;
         timeout_err_q <= force_rel;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   logic unused_timeout;

   assign force_rel      = 1'b0;
   assign timeout_err    = 1'b0;
   assign unused_timeout = (TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_noc_fifo_rr_arb.sv
// Directed bench for noc_fifo_rr_arb with modelled upstream FIFOs and a beat scoreboard.
module tb_noc_fifo_rr_arb;

   localparam int WID  = 32;
   localparam int NREQ = 4;
   localparam int IDW  = 2;
`ifdef ARB_TIMEOUT_EN
   localparam int STALL_N = 3;
`else
   localparam int STALL_N = 5;
`endif

   logic                clk;
   logic                rst;
   logic                softreset;
   logic [NREQ-1:0]     in_empty;
   logic [NREQ*WID-1:0] in_data;
   logic [NREQ-1:0]     in_last;
   logic [NREQ-1:0]     in_readout;
   logic                out_full;
   logic                out_vld;
   logic [WID-1:0]      out_data;
   logic                out_last;
   logic [IDW-1:0]      out_id;
   logic                busy;
   logic                timeout_err;

   noc_fifo_rr_arb #(
      .WID     (WID),
      .NREQ    (NREQ),
      .IDW     (IDW),
      .TIMEOUT (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .softreset   (softreset),
      .in_empty    (in_empty),
      .in_data     (in_data),
      .in_last     (in_last),
      .in_readout  (in_readout),
      .out_full    (out_full),
      .out_vld     (out_vld),
      .out_data    (out_data),
      .out_last    (out_last),
      .out_id      (out_id),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [WID:0]         q0[$];
   logic [WID:0]         q1[$];
   logic [WID:0]         q2[$];
   logic [WID:0]         q3[$];
   logic [IDW+WID:0]     exp_q[$];

   logic [NREQ-1:0] s_rd;
   logic            s_busy;
   logic            s_terr;
   logic            s_vld;
   logic [IDW-1:0]  s_id;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int r, input logic l, input logic [WID-1:0] d);
      case (r)
         0: q0.push_back({l, d});
         1: q1.push_back({l, d});
         2: q2.push_back({l, d});
         default: q3.push_back({l, d});
      endcase
   endtask

   task automatic expb(input int id, input logic l, input logic [WID-1:0] d);
      exp_q.push_back({IDW'(id), l, d});
   endtask

   task automatic drive_heads();
      in_empty = '1;
      in_data  = '0;
      in_last  = '0;
      if (q0.size() > 0) begin in_empty[0] = 1'b0; in_data[0*WID +: WID] = q0[0][WID-1:0]; in_last[0] = q0[0][WID]; end
      if (q1.size() > 0) begin in_empty[1] = 1'b0; in_data[1*WID +: WID] = q1[0][WID-1:0]; in_last[1] = q1[0][WID]; end
      if (q2.size() > 0) begin in_empty[2] = 1'b0; in_data[2*WID +: WID] = q2[0][WID-1:0]; in_last[2] = q2[0][WID]; end
      if (q3.size() > 0) begin in_empty[3] = 1'b0; in_data[3*WID +: WID] = q3[0][WID-1:0]; in_last[3] = q3[0][WID]; end
   endtask

   // One clock: sample at negedge, check invariants and scoreboard, pop after posedge.
   task automatic step();
      logic [IDW+WID:0] item;
      @(negedge clk);
      s_rd   = in_readout;
      s_vld  = out_vld;
      s_id   = out_id;
      s_busy = busy;
      s_terr = timeout_err;
      chk("vld_vs_readout", 64'(out_vld), 64'(|in_readout));
      chk("readout_onehot0", 64'($onehot0(in_readout)), 64'(1));
      chk("readout_to_empty", 64'(in_readout & in_empty), 64'(0));
      if (out_vld) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_beat", 64'({out_id, out_last, out_data}), 64'(0));
         end else begin
            item = exp_q.pop_front();
            chk("sb_beat", 64'({out_id, out_last, out_data}), 64'(item));
         end
      end
      @(posedge clk);
      #1;
      if (s_rd[0] && q0.size() > 0) void'(q0.pop_front());
      if (s_rd[1] && q1.size() > 0) void'(q1.pop_front());
      if (s_rd[2] && q2.size() > 0) void'(q2.pop_front());
      if (s_rd[3] && q3.size() > 0) void'(q3.pop_front());
      drive_heads();
   endtask

   task automatic check_out(input string tag, input logic [NREQ-1:0] exp_rd, input int exp_id,
                            input logic exp_busy, input logic exp_terr = 1'b0);
      chk({tag, "_rd"}, 64'(s_rd), 64'(exp_rd));
      chk({tag, "_vld"}, 64'(s_vld), 64'(exp_rd != '0));
      if (exp_rd != '0) chk({tag, "_id"}, 64'(s_id), 64'(exp_id));
      chk({tag, "_busy"}, 64'(s_busy), 64'(exp_busy));
      chk({tag, "_terr"}, 64'(s_terr), 64'(exp_terr));
   endtask

   initial begin
      rst       = 1'b1;
      softreset = 1'b0;
      out_full  = 1'b0;
      drive_heads();

      // Reset state
      @(negedge clk);
      chk("rst_vld", 64'(out_vld), 64'(0));
      chk("rst_readout", 64'(in_readout), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_id", 64'(out_id), 64'(0));
      chk("rst_terr", 64'(timeout_err), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single-beat packets on 0 and 2
      push(0, 1'b1, 32'hA0); expb(0, 1'b1, 32'hA0);
      push(2, 1'b1, 32'hA2); expb(2, 1'b1, 32'hA2);
      drive_heads();
      step(); check_out("sb_c1", 4'b0001, 0, 1'b0);
      step(); check_out("sb_c2", 4'b0100, 2, 1'b0);
      step(); check_out("sb_idle", 4'b0000, 0, 1'b0);

      // Move the pointer to 0 so requester 1 wins next
      push(0, 1'b1, 32'hB0); expb(0, 1'b1, 32'hB0);
      drive_heads();
      step(); check_out("ptr0", 4'b0001, 0, 1'b0);

      // 3-beat packet on 1 with 3 pending
      push(1, 1'b0, 32'h11); expb(1, 1'b0, 32'h11);
      push(1, 1'b0, 32'h12); expb(1, 1'b0, 32'h12);
      push(1, 1'b1, 32'h13); expb(1, 1'b1, 32'h13);
      push(3, 1'b1, 32'h33); expb(3, 1'b1, 32'h33);
      drive_heads();
      step(); check_out("pkt_b1", 4'b0010, 1, 1'b0);
      step(); check_out("pkt_b2", 4'b0010, 1, 1'b1);
      step(); check_out("pkt_b3", 4'b0010, 1, 1'b1);
      step(); check_out("pkt_r3", 4'b1000, 3, 1'b0);

      // Requester 0 stalls mid-packet while 1 waits
      push(0, 1'b0, 32'hC0); expb(0, 1'b0, 32'hC0);
      push(1, 1'b1, 32'hD1);
      drive_heads();
      step(); check_out("stall_b1", 4'b0001, 0, 1'b0);
      for (int i = 0; i < STALL_N; i++) begin
         step(); check_out("stall_hold", 4'b0000, 0, 1'b1);
      end
      push(0, 1'b1, 32'hC1); expb(0, 1'b1, 32'hC1);
      expb(1, 1'b1, 32'hD1);
      drive_heads();
      step(); check_out("stall_resume", 4'b0001, 0, 1'b1);
      step(); check_out("stall_r1", 4'b0010, 1, 1'b0);

      // Pointer to 3, then back-pressure with all four pending
      push(3, 1'b1, 32'hF3); expb(3, 1'b1, 32'hF3);
      drive_heads();
      step(); check_out("ptr3", 4'b1000, 3, 1'b0);
      out_full = 1'b1;
      for (int r = 0; r < NREQ; r++) begin
         push(r, 1'b1, 32'hE0 + 32'(r)); expb(r, 1'b1, 32'hE0 + 32'(r));
      end
      drive_heads();
      for (int i = 0; i < 3; i++) begin
         step(); check_out("full_hold", 4'b0000, 0, 1'b0);
      end
      out_full = 1'b0;
      step(); check_out("full_g0", 4'b0001, 0, 1'b0);
      step(); check_out("full_g1", 4'b0010, 1, 1'b0);
      step(); check_out("full_g2", 4'b0100, 2, 1'b0);
      step(); check_out("full_g3", 4'b1000, 3, 1'b0);
      step(); check_out("full_done", 4'b0000, 0, 1'b0);

      // softreset while locked on 2
      push(2, 1'b0, 32'h21); expb(2, 1'b0, 32'h21);
      push(2, 1'b1, 32'h22);
      drive_heads();
      step(); check_out("srst_lock", 4'b0100, 2, 1'b0);
      push(0, 1'b1, 32'h90); expb(0, 1'b1, 32'h90);
      expb(2, 1'b1, 32'h22);
      drive_heads();
      softreset = 1'b1;
      step(); check_out("srst_cycle", 4'b0000, 0, 1'b1);
      softreset = 1'b0;
      step(); check_out("srst_r0", 4'b0001, 0, 1'b0);
      step(); check_out("srst_r2", 4'b0100, 2, 1'b0);

`ifdef ARB_TIMEOUT_EN
      // Forced release after TIMEOUT empty cycles on requester 3
      push(3, 1'b0, 32'h31); expb(3, 1'b0, 32'h31);
      push(0, 1'b1, 32'h01); expb(0, 1'b1, 32'h01);
      drive_heads();
      step(); check_out("to_lock", 4'b1000, 3, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(); check_out("to_wait", 4'b0000, 0, 1'b1);
      end
      step(); check_out("to_pulse", 4'b0001, 0, 1'b0, 1'b1);
      step(); check_out("to_after", 4'b0000, 0, 1'b0);
`endif

      chk("sb_drain", 64'(exp_q.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
